// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states
// and parameter range helpers.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int MAX_WAIT_CYCLES = 15;
  localparam int MIN_DEPTH_WORDS = 4;
  localparam int MAX_DEPTH_WORDS = 4096;

  function automatic bit wait_cycles_ok(int w);
    return (w >= 0) && (w <= MAX_WAIT_CYCLES);
  endfunction

  function automatic bit depth_ok(int d);
    return (d >= MIN_DEPTH_WORDS) && (d <= MAX_DEPTH_WORDS) && ((d & (d - 1)) == 0);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: byte enables and replicated store data for
// writes, lane extraction plus sign/zero extension for loads.
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_word,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  assign rd_byte = 8'(rdata_word >> {addr_lo, 3'b000});
  assign rd_half = addr_lo[1] ? rdata_word[31:16] : rdata_word[15:0];

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    byte_en    = 4'b0000;
    wdata_lane = 32'h0;
    rdata_ext  = 32'h0;
    case (size)
      SIZE_BYTE: begin
        byte_en    = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = load_unsigned ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      end
      SIZE_HALF: begin
        byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = load_unsigned ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
      end
      SIZE_WORD: begin
        byte_en    = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = rdata_word;
      end
      default: begin
        byte_en    = 4'b0000;
        wdata_lane = 32'h0;
        rdata_ext  = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits WAIT_CYCLES,
// performs the access on the edge entering RESP and holds the response until taken.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W  = $clog2(DEPTH_WORDS);
  localparam int ADDR_W = IDX_W + 2;
  localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  if (!wait_cycles_ok(WAIT_CYCLES)) begin : gen_bad_wait
    $error("dmem_responder: WAIT_CYCLES out of range 0..15");
  end
  if (!depth_ok(DEPTH_WORDS)) begin : gen_bad_depth
    $error("dmem_responder: DEPTH_WORDS must be a power of two in 4..4096");
  end

  state_e      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        we_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [1:0]  size_reg;
  logic        uns_reg;
  logic        accept;
  logic        enter_resp;

  logic        acc_we;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [1:0]  acc_size;
  logic        acc_uns;
  logic        acc_err;
  logic [IDX_W-1:0] acc_idx;

  logic [3:0]  byte_en;
  logic [31:0] wdata_lane;
  logic [31:0] rd_word;
  logic [31:0] rdata_ext;

  assign accept = req_valid && req_ready;

  // With no wait states the access coincides with the accept edge, so the
  // live request is used; otherwise the captured copy is.
  assign acc_we    = ZERO_WAIT ? req_we       : we_reg;
  assign acc_addr  = ZERO_WAIT ? req_addr     : addr_reg;
  assign acc_wdata = ZERO_WAIT ? req_wdata    : wdata_reg;
  assign acc_size  = ZERO_WAIT ? req_size     : size_reg;
  assign acc_uns   = ZERO_WAIT ? req_unsigned : uns_reg;
  assign acc_idx   = acc_addr[ADDR_W-1:2];

  assign acc_err = (acc_size == SIZE_ILL)
                || ((acc_size == SIZE_HALF) && acc_addr[0])
                || ((acc_size == SIZE_WORD) && (acc_addr[1:0] != 2'b00))
                || (acc_addr[31:ADDR_W] != '0);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    req_ready  = 1'b0;
    enter_resp = 1'b0;
    if (!rst) begin
      case (state_reg)
        IDLE: begin
          req_ready = 1'b1;
          if (req_valid) begin
            if (ZERO_WAIT) begin
              state_next = RESP;
              enter_resp = 1'b1;
            end else begin
              state_next = WAIT;
              cnt_next   = WAIT_LOAD;
            end
          end
        end
        WAIT: begin
          if (cnt_reg == 4'd0) begin
            state_next = RESP;
            enter_resp = 1'b1;
          end else begin
            cnt_next = cnt_reg - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      we_reg    <= 1'b0;
      addr_reg  <= 32'h0;
      wdata_reg <= 32'h0;
      size_reg  <= 2'b00;
      uns_reg   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        we_reg    <= req_we;
        addr_reg  <= req_addr;
        wdata_reg <= req_wdata;
        size_reg  <= req_size;
        uns_reg   <= req_unsigned;
      end
      if (enter_resp) begin
        rsp_valid <= 1'b1;
        rsp_err   <= acc_err;
        rsp_rdata <= (acc_err || acc_we) ? 32'h0 : rdata_ext;
      end else if ((state_reg == RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  dmem_lane_align u_align (
    .addr_lo       (acc_addr[1:0]),
    .size          (acc_size),
    .load_unsigned (acc_uns),
    .wdata         (acc_wdata),
    .rdata_word    (rd_word),
    .byte_en       (byte_en),
    .wdata_lane    (wdata_lane),
    .rdata_ext     (rdata_ext)
  );

  // One byte-wide array per lane keeps partial writes free of read-modify-write.
  for (genvar gi = 0; gi < 4; gi++) begin : gen_lane
    logic [7:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 8'h0;
      end else if (enter_resp && acc_we && !acc_err && byte_en[gi]) begin
        mem[acc_idx] <= wdata_lane[8*gi +: 8];
      end
    end

    assign rd_word[8*gi +: 8] = mem[acc_idx];
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with one wait state, one with none,
// checked against a byte-addressed memory model.
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int NBYTES = DEPTH * 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst          [2];
  logic        req_valid    [2];
  logic        req_ready    [2];
  logic        req_we       [2];
  logic [31:0] req_addr     [2];
  logic [31:0] req_wdata    [2];
  logic [1:0]  req_size     [2];
  logic        req_unsigned [2];
  logic        rsp_valid    [2];
  logic        rsp_ready    [2];
  logic [31:0] rsp_rdata    [2];
  logic        rsp_err      [2];

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES((g == 0) ? 1 : 0)) u_dut (
      .clk          (clk),
      .rst          (rst[g]),
      .req_valid    (req_valid[g]),
      .req_ready    (req_ready[g]),
      .req_we       (req_we[g]),
      .req_addr     (req_addr[g]),
      .req_wdata    (req_wdata[g]),
      .req_size     (req_size[g]),
      .req_unsigned (req_unsigned[g]),
      .rsp_valid    (rsp_valid[g]),
      .rsp_ready    (rsp_ready[g]),
      .rsp_rdata    (rsp_rdata[g]),
      .rsp_err      (rsp_err[g])
    );
  end

  int n_total = 0;
  int n_pass  = 0;
  logic [7:0] mem_b [2][NBYTES];

  function automatic int wait_of(int d);
    return (d == 0) ? 1 : 0;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic void model_clear(int d);
    for (int i = 0; i < NBYTES; i++) mem_b[d][i] = 8'h0;
  endfunction

  // Memory seen as plain little-endian bytes; loads are rebuilt arithmetically.
  function automatic void model_access(int d, logic we, logic [31:0] addr, logic [31:0] wdata,
                                       logic [1:0] size, logic uns,
                                       output logic [31:0] rdata, output logic err);
    longint v;
    int n;
    n = 1 << size;
    rdata = 32'h0;
    err = (size == 2'b11) || ((addr % n) != 0) || (longint'(addr) >= NBYTES);
    if (err) return;
    if (we) begin
      for (int k = 0; k < n; k++) mem_b[d][addr + k] = wdata[8*k +: 8];
    end else begin
      v = 0;
      for (int k = n - 1; k >= 0; k--) v = v * 256 + longint'(mem_b[d][addr + k]);
      if (!uns && n < 4 && v >= (longint'(1) << (8*n - 1))) v = v - (longint'(1) << (8*n));
      rdata = v[31:0];
    end
  endfunction

  task automatic xact(int d, string tag, logic we, logic [31:0] addr, logic [31:0] wdata,
                      logic [1:0] size, logic uns, int hold);
    logic [31:0] exp_rdata;
    logic        exp_err;
    int t;
    int lat;
    model_access(d, we, addr, wdata, size, uns, exp_rdata, exp_err);
    @(negedge clk);
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr;
    req_wdata[d] = wdata; req_size[d] = size; req_unsigned[d] = uns;
    t = 0;
    while (!req_ready[d] && t < 20) begin @(negedge clk); t++; end
    check({tag, " accept"}, 32'(req_ready[d]), 32'd1);
    @(posedge clk); #1;
    // Keep req_valid high with junk fields while busy: the responder must ignore them.
    req_addr[d] = $urandom; req_wdata[d] = $urandom; req_size[d] = 2'($urandom);
    req_we[d] = 1'($urandom); req_unsigned[d] = 1'($urandom);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid[d] && lat < 40);
    check({tag, " latency"}, 32'(lat), 32'(wait_of(d) + 1));
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) @(negedge clk);
      check({tag, " rsp_valid"}, 32'(rsp_valid[d]), 32'd1);
      check({tag, " rdata"}, rsp_rdata[d], exp_rdata);
      check({tag, " err"}, 32'(rsp_err[d]), 32'(exp_err));
      check({tag, " busy"}, 32'(req_ready[d]), 32'd0);
    end
    req_valid[d] = 1'b0;
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[d] = 1'b0;
    check({tag, " idle ready"}, 32'(req_ready[d]), 32'd1);
    check({tag, " idle valid"}, 32'(rsp_valid[d]), 32'd0);
    $display("[%0t] dut%0d %-10s we=%0b addr=%08h wdata=%08h size=%0d uns=%0b hold=%0d -> rdata=%08h err=%0b",
             $time, d, tag, we, addr, wdata, size, uns, hold, exp_rdata, exp_err);
  endtask

  task automatic reset_midop(int d);
    @(negedge clk);
    req_valid[d] = 1'b1; req_we[d] = 1'b1; req_addr[d] = 32'h8;
    req_wdata[d] = 32'hCAFEF00D; req_size[d] = 2'b10; req_unsigned[d] = 1'b0;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    rst[d] = 1'b1;
    @(negedge clk);
    check("midrst ready", 32'(req_ready[d]), 32'd0);
    @(posedge clk); #1;
    rst[d] = 1'b0;
    check("midrst valid", 32'(rsp_valid[d]), 32'd0);
    model_clear(d);
    $display("[%0t] dut%0d reset during SW 0xCAFEF00D @0x8", $time, d);
    xact(d, "LW8", 1'b0, 32'h8, 32'h0, 2'b10, 1'b0, 0);
  endtask

  task automatic random_run(int d, int n);
    logic [31:0] a;
    int sel;
    for (int i = 0; i < n; i++) begin
      sel = $urandom_range(0, 99);
      if (sel < 60)      a = $urandom_range(0, 63);
      else if (sel < 85) a = $urandom_range(0, NBYTES - 1);
      else if (sel < 95) a = $urandom_range(NBYTES, NBYTES + 64);
      else               a = $urandom;
      xact(d, "rand", 1'($urandom), a, $urandom,
           ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
           1'($urandom), $urandom_range(0, 2));
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
      req_wdata[d] = '0; req_size[d] = '0; req_unsigned[d] = 1'b0; rsp_ready[d] = 1'b0;
      model_clear(d);
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst ready", 32'(req_ready[d]), 32'd0);
      check("rst valid", 32'(rsp_valid[d]), 32'd0);
      check("rst rdata", rsp_rdata[d], 32'h0);
      check("rst err", 32'(rsp_err[d]), 32'd0);
      rst[d] = 1'b0;
    end
    @(posedge clk); #1;
    check("post rst ready", 32'(req_ready[0]), 32'd1);

    xact(0, "SW10",  1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 0);
    xact(0, "LW10",  1'b0, 32'h10, 32'h0,        2'b10, 1'b0, 0);
    xact(0, "SW10b", 1'b1, 32'h10, 32'h11223344, 2'b10, 1'b0, 0);
    xact(0, "SB13",  1'b1, 32'h13, 32'h00000080, 2'b00, 1'b0, 0);
    xact(0, "LB13",  1'b0, 32'h13, 32'h0,        2'b00, 1'b0, 0);
    xact(0, "LBU13", 1'b0, 32'h13, 32'h0,        2'b00, 1'b1, 0);
    xact(0, "LW10c", 1'b0, 32'h10, 32'h0,        2'b10, 1'b0, 0);
    xact(0, "SH22",  1'b1, 32'h22, 32'h0000BEEF, 2'b01, 1'b0, 0);
    xact(0, "LH22",  1'b0, 32'h22, 32'h0,        2'b01, 1'b0, 0);
    xact(0, "LW20",  1'b0, 32'h20, 32'h0,        2'b10, 1'b0, 0);
    xact(0, "LW06",  1'b0, 32'h06, 32'h0,        2'b10, 1'b0, 0);
    xact(0, "SW0",   1'b1, 32'h0,  32'h5A5A1234, 2'b10, 1'b0, 0);
    xact(0, "SW400", 1'b1, 32'h400, 32'hFFFFFFFF, 2'b10, 1'b0, 0);
    xact(0, "LW0",   1'b0, 32'h0,  32'h0,        2'b10, 1'b0, 0);
    xact(0, "ILL30", 1'b0, 32'h30, 32'h0,        2'b11, 1'b0, 0);
    xact(0, "BP10",  1'b0, 32'h10, 32'h0,        2'b10, 1'b0, 5);
    random_run(0, 40);
    reset_midop(0);
    random_run(0, 10);

    xact(1, "SW10",  1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 0);
    xact(1, "LHU12", 1'b0, 32'h12, 32'h0,        2'b01, 1'b1, 0);
    xact(1, "LB11",  1'b0, 32'h11, 32'h0,        2'b00, 1'b0, 0);
    xact(1, "BP10",  1'b0, 32'h10, 32'h0,        2'b10, 1'b0, 3);
    random_run(1, 40);
    reset_midop(1);
    random_run(1, 10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the core's load/store port: the target side of a valid/ready request/response handshake.
- Replaces the core-internal combinational array with a separate block that has configurable wait states.
- Supports byte, halfword and word accesses, load sign/zero extension, and alignment/range error reporting.
- Sits between the core's load/store path and the writeback mux.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; power of two, 4..4096.
- WAIT_CYCLES, 1, extra cycles between accept and response; 0..15.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data; lane 0 holds the byte/half value
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  zero-extend loads (LBU/LHU)
- rsp_valid  out  1  response present
- rsp_ready  in  1  core accepts response
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned, illegal size, or out of range

Behaviour:
- Reset (synchronous, active-high):
  - state <= IDLE; rsp_valid, rsp_rdata, rsp_err <= 0.
  - All memory words zeroed.
  - req_ready = 0 during any cycle rst is high.
  - Any in-flight request is dropped and no write is performed.
- FSM states IDLE, WAIT, RESP:
  - IDLE: req_ready = 1. A request is accepted on an edge with req_valid && req_ready; all request fields are captured at that edge. Next state is WAIT if WAIT_CYCLES > 0, else RESP.
  - WAIT: req_ready = 0. Counter loads WAIT_CYCLES-1 at accept and decrements each cycle. At count 0, next state is RESP.
  - RESP: req_ready = 0, rsp_valid = 1. rsp_rdata and rsp_err are held stable until an edge with rsp_ready = 1, then next state is IDLE. No new request is accepted in the same cycle as the response handshake (one outstanding request maximum).
- Access timing:
  - The memory access (read capture or write) happens on the edge entering RESP.
  - When WAIT_CYCLES = 0, that is the accept edge and the live request fields are used. Otherwise the captured fields are used.
- Latency:
  - rsp_valid rises WAIT_CYCLES+1 cycles after the accept cycle.
  - Minimum throughput is one request per WAIT_CYCLES+2 cycles.
- Error check (evaluated on the captured request):
  - size = 11 → error.
  - half with addr[0] = 1 → error.
  - word with addr[1:0] ≠ 00 → error.
  - addr ≥ 4*DEPTH_WORDS → error.
  - On error: rsp_err = 1, rsp_rdata = 0, memory unchanged.
- Word index is addr[log2(DEPTH_WORDS)+1:2].
- Stores:
  - Byte: wdata[7:0] written to lane addr[1:0].
  - Half: wdata[15:0] written to lanes addr[1]*2 and addr[1]*2+1.
  - Word: all four lanes written.
  - Unwritten lanes are preserved.
  - Store response: rsp_rdata = 0, rsp_err = 0.
- Loads:
  - The selected lane is extracted.
  - It is sign-extended unless req_unsigned = 1, in which case it is zero-extended.
  - req_unsigned is ignored for word loads.
- rsp_ready is ignored outside RESP. req_valid is ignored outside IDLE.
- The core must hold request fields stable only until the accept handshake.

Decomposition:
- Shared package:
  - SIZE_BYTE/SIZE_HALF/SIZE_WORD/SIZE_ILL encodings.
  - FSM state encoding (IDLE = 0, WAIT = 1, RESP = 2).
  - WAIT_CYCLES range check.
- One natural sub-module, dmem_lane_align (combinational):
  - Inputs: addr[1:0], size, unsigned, wdata, read word.
  - Outputs: 4-bit byte-enable, lane-shifted store word, extended load word.
- The responder holds the FSM, wait counter, capture registers and array.

Test Plan:
- WAIT_CYCLES = 1: store word 0xDEADBEEF @0x10, then load word @0x10 → rsp_rdata = 0xDEADBEEF, rsp_err = 0, rsp_valid rises 2 cycles after each accept.
- Byte store 0x80 @0x13 over word 0x11223344:
  - LB @0x13 → 0xFFFFFF80.
  - LBU → 0x00000080.
  - LW @0x10 → 0x80223344.
- Half store 0xBEEF @0x22, then LH @0x22 → 0xFFFFBEEF. LW @0x20 after zero reset → 0xBEEF0000.
- Errors:
  - LW @0x06 → rsp_err = 1, rsp_rdata = 0.
  - SW @0x400 (DEPTH 256) → rsp_err = 1; word 0 is unchanged afterwards.
  - size = 11 → rsp_err = 1.
- Backpressure: hold rsp_ready = 0 for 5 cycles in RESP → rsp_valid stays 1 with stable data and req_ready stays 0. IDLE is entered the cycle after rsp_ready = 1.
- Reset mid-operation: assert rst in WAIT during an SW of 0xCAFEF00D @0x8 → next cycle rsp_valid = 0, and a subsequent LW @0x8 returns 0. Repeat with WAIT_CYCLES = 0 and check back-to-back latency of 1.
